key_conditioner: RTL and testbench

//  N-channel conditioner for active-low push-buttons (Run, Continue, spare keys) on the SLC-3 top level.
//  Per key: synchronise, debounce, emit a level plus one-cycle press/release pulses.

---
 rtl/key_cond_pkg.sv | 14 +
 rtl/key_channel.sv | 110 +++++++++++
 rtl/key_conditioner.sv | 42 ++++
 tb/tb_key_conditioner.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/key_cond_pkg.sv
// rtl/key_cond_pkg.sv - shared constants and key state type for the key conditioner
package key_cond_pkg;

    localparam int CLK_HZ                = 50_000_000;
    localparam int DEBOUNCE_1MS          = CLK_HZ / 1000;
    localparam int REPEAT_DEFAULT_DELAY  = CLK_HZ / 2;
    localparam int REPEAT_DEFAULT_PERIOD = CLK_HZ / 10;

    typedef enum logic {
        KEY_RELEASED = 1'b0,
        KEY_HELD     = 1'b1
    } key_state_t;

endpackage

// File: rtl/key_channel.sv
// rtl/key_channel.sv - one key lane: two-flop sync, debounce, optional auto-repeat
module key_channel
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = REPEAT_DEFAULT_DELAY,
    parameter int REPEAT_PERIOD   = REPEAT_DEFAULT_PERIOD
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_ni,
    output logic pressed_o,
    output logic press_pulse_o,
    output logic release_pulse_o
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("key_channel: DEBOUNCE_CYCLES must be >= 1");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("key_channel: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic [1:0]      sync_q;
    key_state_t      state_q, state_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            key_held, mismatch, accept, rep_fire;

    assign key_held = ~sync_q[1];
    assign mismatch = key_held != (state_q == KEY_HELD);
    // The count reaching DEBOUNCE_CYCLES means that many disagreeing cycles have been seen.
    assign accept   = mismatch && (db_cnt_q == DB_W'(DEBOUNCE_CYCLES));

    always_comb begin
        state_d   = state_q;
        db_cnt_d  = '0;
        press_d   = rep_fire;
        release_d = 1'b0;
        if (accept) begin
            state_d   = key_held ? KEY_HELD : KEY_RELEASED;
            press_d   = key_held;
            release_d = ~key_held;
        end else if (mismatch) begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    if (REPEAT_EN != 0) begin : g_repeat
        logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
        logic             rep_phase_q, rep_phase_d;
        logic             stay_held;
        logic [REP_W-1:0] rep_last;

        // A release edge wins over a repeat that would land in the same cycle.
        assign stay_held = (state_q == KEY_HELD) && !accept;
        assign rep_last  = rep_phase_q ? REP_W'(REPEAT_PERIOD - 1) : REP_W'(REPEAT_DELAY - 1);
        assign rep_fire  = stay_held && (rep_cnt_q == rep_last);

        always_comb begin
            rep_cnt_d   = '0;
            rep_phase_d = 1'b0;
            if (rep_fire) begin
                rep_phase_d = 1'b1;
            end else if (stay_held) begin
                rep_cnt_d   = rep_cnt_q + 1'b1;
                rep_phase_d = rep_phase_q;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rep_cnt_q   <= '0;
                rep_phase_q <= 1'b0;
            end else begin
                rep_cnt_q   <= rep_cnt_d;
                rep_phase_q <= rep_phase_d;
            end
        end
    end else begin : g_no_repeat
        assign rep_fire = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q    <= 2'b11;
            state_q   <= KEY_RELEASED;
            db_cnt_q  <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], key_ni};
            state_q   <= state_d;
            db_cnt_q  <= db_cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign pressed_o       = (state_q == KEY_HELD);
    assign press_pulse_o   = press_q;
    assign release_pulse_o = release_q;

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - N independent push-button conditioners plus an any-key flag
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int N_KEYS          = 3,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = REPEAT_DEFAULT_DELAY,
    parameter int REPEAT_PERIOD   = REPEAT_DEFAULT_PERIOD
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [N_KEYS-1:0] Key_n,
    output logic [N_KEYS-1:0] Pressed,
    output logic [N_KEYS-1:0] Press_pulse,
    output logic [N_KEYS-1:0] Release_pulse,
    output logic              Any_pressed
);

    if (N_KEYS < 1) begin : g_bad_n_keys
        $error("key_conditioner: N_KEYS must be >= 1");
    end

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        key_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_EN      (REPEAT_EN),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_channel (
            .clk_i          (Clk),
            .rst_ni         (Reset),
            .key_ni         (Key_n[g]),
            .pressed_o      (Pressed[g]),
            .press_pulse_o  (Press_pulse[g]),
            .release_pulse_o(Release_pulse[g])
        );
    end

    assign Any_pressed = |Pressed;

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - scoreboard bench for key_conditioner with short debounce/repeat timing
module tb_key_conditioner;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [2:0] Key_n;
    logic [2:0] Pressed, Press_pulse, Release_pulse;
    logic       Any_pressed;

    typedef struct {
        int         cyc;
        logic [2:0] press;
        logic [2:0] rel;
    } exp_t;

    exp_t       sb[$];
    int         cyc     = 0;
    int         total   = 0;
    int         passed  = 0;
    logic [2:0] exp_lvl = '0;

    key_conditioner #(
        .N_KEYS         (3),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_EN      (1),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Key_n        (Key_n),
        .Pressed      (Pressed),
        .Press_pulse  (Press_pulse),
        .Release_pulse(Release_pulse),
        .Any_pressed  (Any_pressed)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic push_exp(input int c, input logic [2:0] p, input logic [2:0] r);
        exp_t e;
        e.cyc = c; e.press = p; e.rel = r;
        sb.push_back(e);
    endtask

    task automatic pop_expected(output logic [2:0] ep, output logic [2:0] er);
        ep = '0;
        er = '0;
        if (sb.size() != 0 && sb[0].cyc == cyc) begin
            ep = sb[0].press;
            er = sb[0].rel;
            sb.delete(0);
        end
        exp_lvl = (exp_lvl | ep) & ~er;
    endtask

    task automatic test_reset();
        logic [2:0] ep, er;
        Reset = 1'b0;
        Key_n = 3'b111;
        sb.delete();
        exp_lvl = '0;
        for (int i = 0; i < 22; i++) begin
            if (i == 2) Reset = 1'b1;
            @(negedge Clk);
            pop_expected(ep, er);
            total++;
            if ({Pressed, Press_pulse, Release_pulse, Any_pressed} !== {exp_lvl, ep, er, |exp_lvl})
                $display("FAIL reset cyc=%0d got lvl=%b pp=%b rp=%b any=%b exp lvl=%b pp=%b rp=%b any=%b",
                         cyc, Pressed, Press_pulse, Release_pulse, Any_pressed, exp_lvl, ep, er, |exp_lvl);
            else passed++;
        end
    endtask

    task automatic test_press_release();
        int c0;
        logic [2:0] ep, er;
        c0 = cyc;
        push_exp(c0 + 7,  3'b001, 3'b000);
        push_exp(c0 + 13, 3'b000, 3'b001);
        for (int i = 0; i < 18; i++) begin
            if (i == 0) Key_n[0] = 1'b0;
            if (i == 6) Key_n[0] = 1'b1;
            @(negedge Clk);
            pop_expected(ep, er);
            total++;
            if ({Pressed, Press_pulse, Release_pulse, Any_pressed} !== {exp_lvl, ep, er, |exp_lvl})
                $display("FAIL press_release cyc=%0d got lvl=%b pp=%b rp=%b any=%b exp lvl=%b pp=%b rp=%b any=%b",
                         cyc, Pressed, Press_pulse, Release_pulse, Any_pressed, exp_lvl, ep, er, |exp_lvl);
            else passed++;
        end
        total++;
        if (sb.size() != 0) $display("FAIL press_release_pending got %0d exp 0", sb.size());
        else passed++;
    endtask

    task automatic test_bounce();
        int c0;
        logic [2:0] ep, er;
        c0 = cyc;
        push_exp(c0 + 11, 3'b010, 3'b000);
        push_exp(c0 + 20, 3'b000, 3'b010);
        for (int i = 0; i < 26; i++) begin
            if (i == 0)  Key_n[1] = 1'b0;
            if (i == 3)  Key_n[1] = 1'b1;
            if (i == 4)  Key_n[1] = 1'b0;
            if (i == 13) Key_n[1] = 1'b1;
            @(negedge Clk);
            pop_expected(ep, er);
            total++;
            if ({Pressed, Press_pulse, Release_pulse, Any_pressed} !== {exp_lvl, ep, er, |exp_lvl})
                $display("FAIL bounce cyc=%0d got lvl=%b pp=%b rp=%b any=%b exp lvl=%b pp=%b rp=%b any=%b",
                         cyc, Pressed, Press_pulse, Release_pulse, Any_pressed, exp_lvl, ep, er, |exp_lvl);
            else passed++;
        end
        total++;
        if (sb.size() != 0) $display("FAIL bounce_pending got %0d exp 0", sb.size());
        else passed++;
    endtask

    task automatic test_repeat();
        int c0, t, r;
        logic [2:0] ep, er;
        c0 = cyc;
        t  = c0 + 7;
        r  = t + 37;
        push_exp(t, 3'b100, 3'b000);
        for (int p = t + 10; p < r; p += 3) push_exp(p, 3'b100, 3'b000);
        push_exp(r, 3'b000, 3'b100);
        for (int i = 0; i < 52; i++) begin
            if (i == 0)  Key_n[2] = 1'b0;
            if (i == 37) Key_n[2] = 1'b1;
            @(negedge Clk);
            pop_expected(ep, er);
            total++;
            if ({Pressed, Press_pulse, Release_pulse, Any_pressed} !== {exp_lvl, ep, er, |exp_lvl})
                $display("FAIL repeat cyc=%0d got lvl=%b pp=%b rp=%b any=%b exp lvl=%b pp=%b rp=%b any=%b",
                         cyc, Pressed, Press_pulse, Release_pulse, Any_pressed, exp_lvl, ep, er, |exp_lvl);
            else passed++;
        end
        total++;
        if (sb.size() != 0) $display("FAIL repeat_pending got %0d exp 0", sb.size());
        else passed++;
    endtask

    task automatic test_reset_mid();
        int c0;
        logic [2:0] ep, er;
        c0 = cyc;
        for (int i = 0; i < 24; i++) begin
            if (i == 0) Key_n[0] = 1'b0;
            if (i == 3) begin
                Reset = 1'b0;
                sb.delete();
                exp_lvl = '0;
            end
            if (i == 5) begin
                Reset = 1'b1;
                push_exp(c0 + 12, 3'b001, 3'b000);
                push_exp(c0 + 17, 3'b000, 3'b001);
            end
            if (i == 10) Key_n[0] = 1'b1;
            @(negedge Clk);
            pop_expected(ep, er);
            total++;
            if ({Pressed, Press_pulse, Release_pulse, Any_pressed} !== {exp_lvl, ep, er, |exp_lvl})
                $display("FAIL reset_mid cyc=%0d got lvl=%b pp=%b rp=%b any=%b exp lvl=%b pp=%b rp=%b any=%b",
                         cyc, Pressed, Press_pulse, Release_pulse, Any_pressed, exp_lvl, ep, er, |exp_lvl);
            else passed++;
        end
        total++;
        if (sb.size() != 0) $display("FAIL reset_mid_pending got %0d exp 0", sb.size());
        else passed++;
    endtask

    task automatic test_back_to_back();
        int c0;
        logic [2:0] ep, er;
        c0 = cyc;
        push_exp(c0 + 7,  3'b101, 3'b000);
        push_exp(c0 + 14, 3'b000, 3'b001);
        push_exp(c0 + 16, 3'b000, 3'b100);
        for (int i = 0; i < 22; i++) begin
            if (i == 0) Key_n = 3'b010;
            if (i == 7) Key_n[0] = 1'b1;
            if (i == 9) Key_n[2] = 1'b1;
            @(negedge Clk);
            pop_expected(ep, er);
            total++;
            if ({Pressed, Press_pulse, Release_pulse, Any_pressed} !== {exp_lvl, ep, er, |exp_lvl})
                $display("FAIL back_to_back cyc=%0d got lvl=%b pp=%b rp=%b any=%b exp lvl=%b pp=%b rp=%b any=%b",
                         cyc, Pressed, Press_pulse, Release_pulse, Any_pressed, exp_lvl, ep, er, |exp_lvl);
            else passed++;
        end
        total++;
        if (sb.size() != 0) $display("FAIL back_to_back_pending got %0d exp 0", sb.size());
        else passed++;
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_bounce();
        test_repeat();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
